// File: rtl/riscv_mmio_store_if.sv
// Store-path bus between the memory stage / UART transmitter and riscv_mmio_store.
// Member names match the legacy flat ports so existing hookups map one-to-one.
interface riscv_mmio_store_if #(
  parameter int unsigned TX_DEPTH = 8
);
  localparam int unsigned LW = $clog2(TX_DEPTH) + 1;

  logic          i_riscv_mmiostore_en;
  logic [63:0]   i_riscv_mmiostore_addr;
  logic [63:0]   i_riscv_mmiostore_wdata;
  logic [1:0]    i_riscv_mmiostore_size;
  logic          o_riscv_mmiostore_dm_wen;
  logic [63:0]   o_riscv_mmiostore_dm_addr;
  logic [63:0]   o_riscv_mmiostore_dm_wdata;
  logic [7:0]    o_riscv_mmiostore_dm_mask;
  logic          o_riscv_mmiostore_timer_wen;
  logic [15:0]   o_riscv_mmiostore_leds;
  logic [31:0]   o_riscv_mmiostore_seg;
  logic [7:0]    o_riscv_mmiostore_tx_data;
  logic          o_riscv_mmiostore_tx_valid;
  logic          i_riscv_mmiostore_tx_ready;
  logic [LW-1:0] o_riscv_mmiostore_tx_level;
  logic          o_riscv_mmiostore_stall;
  logic          o_riscv_mmiostore_misaligned;

  modport master (
    output i_riscv_mmiostore_en, i_riscv_mmiostore_addr, i_riscv_mmiostore_wdata,
           i_riscv_mmiostore_size, i_riscv_mmiostore_tx_ready,
    input  o_riscv_mmiostore_dm_wen, o_riscv_mmiostore_dm_addr, o_riscv_mmiostore_dm_wdata,
           o_riscv_mmiostore_dm_mask, o_riscv_mmiostore_timer_wen, o_riscv_mmiostore_leds,
           o_riscv_mmiostore_seg, o_riscv_mmiostore_tx_data, o_riscv_mmiostore_tx_valid,
           o_riscv_mmiostore_tx_level, o_riscv_mmiostore_stall, o_riscv_mmiostore_misaligned
  );

  modport slave (
    input  i_riscv_mmiostore_en, i_riscv_mmiostore_addr, i_riscv_mmiostore_wdata,
           i_riscv_mmiostore_size, i_riscv_mmiostore_tx_ready,
    output o_riscv_mmiostore_dm_wen, o_riscv_mmiostore_dm_addr, o_riscv_mmiostore_dm_wdata,
           o_riscv_mmiostore_dm_mask, o_riscv_mmiostore_timer_wen, o_riscv_mmiostore_leds,
           o_riscv_mmiostore_seg, o_riscv_mmiostore_tx_data, o_riscv_mmiostore_tx_valid,
           o_riscv_mmiostore_tx_level, o_riscv_mmiostore_stall, o_riscv_mmiostore_misaligned
  );
endinterface

// File: rtl/riscv_mmio_store.sv
// Memory-stage store path: byte-lane DM writes, mtimecmp strobe, LED/SEG registers
// and a buffered UART TX FIFO that stalls the pipeline when full.
module riscv_mmio_store #(
  parameter int unsigned TX_DEPTH   = 8,
  parameter logic [63:0] DM_BYTES   = 64'h0000_0000_0001_0000,
  parameter logic [63:0] LED_ADDR   = 64'h0000_0000_1000_0000,
  parameter logic [63:0] SEG_ADDR   = 64'h0000_0000_1000_0008,
  parameter logic [63:0] UART_ADDR  = 64'h0000_0000_1000_0010,
  parameter logic [63:0] TIMER_ADDR = 64'h0000_0000_0200_4000
) (
  input  logic              i_riscv_mmiostore_clk,
  input  logic              i_riscv_mmiostore_rst,
  riscv_mmio_store_if.slave bus
);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [63:0]   addr;
  logic [7:0]    mask_base;
  logic [7:0]    mask;
  logic [63:0]   wdata_sh;
  logic          misaligned;
  logic          valid_st;
  logic          led_hit, seg_hit, uart_hit, timer_hit, dm_hit;
  logic          full;
  logic          push, pop;
  logic [15:0]   leds;
  logic [31:0]   seg;
  logic [7:0]    mem [TX_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level;

  assign addr = bus.i_riscv_mmiostore_addr;

  always_comb begin
    mask_base = 8'h01;
    unique case (bus.i_riscv_mmiostore_size)
      2'b00: mask_base = 8'h01;
      2'b01: mask_base = 8'h03;
      2'b10: mask_base = 8'h0F;
      2'b11: mask_base = 8'hFF;
    endcase
  end

  assign mask     = mask_base << addr[2:0];
  assign wdata_sh = bus.i_riscv_mmiostore_wdata << {addr[2:0], 3'b000};

  always_comb begin
    misaligned = 1'b0;
    unique case (bus.i_riscv_mmiostore_size)
      2'b00: misaligned = 1'b0;
      2'b01: misaligned = addr[0];
      2'b10: misaligned = addr[1:0] != 2'b00;
      2'b11: misaligned = addr[2:0] != 3'b000;
    endcase
    misaligned = misaligned & bus.i_riscv_mmiostore_en;
  end

  assign valid_st = bus.i_riscv_mmiostore_en & ~misaligned;

  // MMIO doublewords take precedence so a store never hits DM and a register at once
  assign led_hit   = addr[63:3] == LED_ADDR[63:3];
  assign seg_hit   = addr[63:3] == SEG_ADDR[63:3];
  assign uart_hit  = addr[63:3] == UART_ADDR[63:3];
  assign timer_hit = addr[63:3] == TIMER_ADDR[63:3];
  assign dm_hit    = ~(led_hit | seg_hit | uart_hit | timer_hit) && (addr < DM_BYTES);

  assign full = level == LW'(TX_DEPTH);
  assign push = valid_st & uart_hit & mask[0] & ~full;
  assign pop  = (level != '0) & bus.i_riscv_mmiostore_tx_ready;

  always_ff @(posedge i_riscv_mmiostore_clk) begin
    if (i_riscv_mmiostore_rst) begin
      leds <= '0;
      seg  <= '0;
    end else begin
      if (valid_st && led_hit) begin
        for (int unsigned l = 0; l < 2; l++)
          if (mask[l]) leds[8*l +: 8] <= wdata_sh[8*l +: 8];
      end
      if (valid_st && seg_hit) begin
        for (int unsigned l = 0; l < 4; l++)
          if (mask[l]) seg[8*l +: 8] <= wdata_sh[8*l +: 8];
      end
    end
  end

  always_ff @(posedge i_riscv_mmiostore_clk) begin
    if (i_riscv_mmiostore_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge i_riscv_mmiostore_clk) begin
    if (push) mem[wptr] <= bus.i_riscv_mmiostore_wdata[7:0];
  end

  assign bus.o_riscv_mmiostore_dm_wen     = valid_st & dm_hit;
  assign bus.o_riscv_mmiostore_dm_addr    = {addr[63:3], 3'b000};
  assign bus.o_riscv_mmiostore_dm_wdata   = wdata_sh;
  assign bus.o_riscv_mmiostore_dm_mask    = mask;
  assign bus.o_riscv_mmiostore_timer_wen  = valid_st & timer_hit;
  assign bus.o_riscv_mmiostore_leds       = leds;
  assign bus.o_riscv_mmiostore_seg        = seg;
  assign bus.o_riscv_mmiostore_tx_valid   = level != '0;
  assign bus.o_riscv_mmiostore_tx_data    = (level != '0) ? mem[rptr] : '0;
  assign bus.o_riscv_mmiostore_tx_level   = level;
  assign bus.o_riscv_mmiostore_stall      = valid_st & uart_hit & mask[0] & full;
  assign bus.o_riscv_mmiostore_misaligned = misaligned;
endmodule

// File: doc/riscv_mmio_store.md
Name: riscv_mmio_store

Overview:
Store-side counterpart of the memory-stage load path. Takes committed stores from the memory stage and produces byte-lane-aligned data memory writes, decoded by address. The same store path also feeds the mtimecmp timer write strobe, the LED and seven-segment output registers, and a buffered UART transmit FIFO with a valid/ready interface. It raises a pipeline stall when a UART store cannot be accepted.

Parameters:
TX_DEPTH, 8, UART TX FIFO entries (power of two, >=2)
DM_BYTES, 64'h0000_0000_0001_0000, data memory size; addresses below it map to DM
LED_ADDR, 64'h0000_0000_1000_0000, LED register doubleword
SEG_ADDR, 64'h0000_0000_1000_0008, seven-segment register doubleword
UART_ADDR, 64'h0000_0000_1000_0010, UART TX data doubleword
TIMER_ADDR, 64'h0000_0000_0200_4000, mtimecmp doubleword

Ports:
i_riscv_mmiostore_clk  in  1  clock
i_riscv_mmiostore_rst  in  1  synchronous active-high reset
i_riscv_mmiostore_en  in  1  store commit strobe, one cycle per store
i_riscv_mmiostore_addr  in  64  byte address
i_riscv_mmiostore_wdata  in  64  store data, right-justified
i_riscv_mmiostore_size  in  2  00 byte, 01 half, 10 word, 11 double
o_riscv_mmiostore_dm_wen  out  1  DM write enable
o_riscv_mmiostore_dm_addr  out  64  DM address, bits [2:0] forced to 0
o_riscv_mmiostore_dm_wdata  out  64  lane-shifted data
o_riscv_mmiostore_dm_mask  out  8  byte-lane mask
o_riscv_mmiostore_timer_wen  out  1  mtimecmp write strobe
o_riscv_mmiostore_leds  out  16  LED register
o_riscv_mmiostore_seg  out  32  seven-segment register
o_riscv_mmiostore_tx_data  out  8  FIFO head byte
o_riscv_mmiostore_tx_valid  out  1  FIFO non-empty
i_riscv_mmiostore_tx_ready  in  1  UART transmitter accepts the head byte
o_riscv_mmiostore_tx_level  out  $clog2(TX_DEPTH)+1  FIFO occupancy
o_riscv_mmiostore_stall  out  1  hold the memory stage
o_riscv_mmiostore_misaligned  out  1  store-address-misaligned flag

Behaviour:
- Clock and reset: single clock i_riscv_mmiostore_clk. Reset i_riscv_mmiostore_rst is synchronous, active-high.
- Reset values: leds=0, seg=0, FIFO empty (tx_valid=0, tx_level=0, tx_data=0), stall=0.
- Lane alignment (combinational):
  - shift = addr[2:0]*8.
  - dm_wdata = wdata << shift.
  - mask = (8'h01, 8'h03, 8'h0F, 8'hFF by size) << addr[2:0].
- Misalignment:
  - misaligned = en & ((half & addr[0]) | (word & addr[1:0]!=0) | (double & addr[2:0]!=0)).
  - A misaligned store performs no write and no push.
- Decode: compare addr[63:3]; exactly one target per store.
  - LED/SEG/UART/TIMER: match on the configured address.
  - DM: all other addresses < DM_BYTES.
  - Anything else: silently dropped.
- DM: dm_wen = en & DM hit & ~misaligned. All DM outputs are combinational, zero-latency.
- TIMER: timer_wen is the same as dm_wen but on a TIMER hit. It shares dm_wdata and dm_mask.
- LED: on a valid hit, updated at the next edge, per byte lane.
  - Lane 0 -> leds[7:0], lane 1 -> leds[15:8]; other lanes ignored.
- SEG: same rule as LED, lanes 0-3 -> seg[31:0].
- UART push:
  - Condition: en & UART hit & ~misaligned & mask[0] & ~full. Pushes wdata[7:0].
  - A UART store with mask[0]=0 (e.g. sb to UART_ADDR+1) is dropped.
- UART pop:
  - tx_valid=1 whenever level>0; tx_data = head entry.
  - Pop on tx_valid & tx_ready.
  - tx_data/tx_valid must hold stable while valid & ~ready.
- FIFO storage: circular buffer with wrapping read/write pointers. level counts 0..TX_DEPTH.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - Pop while empty: no effect.
- Stall:
  - stall = en & UART hit & ~misaligned & mask[0] & full. Combinational, from the registered full flag.
  - A pop in the same cycle does not clear the stall; the upstream re-presents the store and it pushes next cycle.
  - While stalled, no push.
  - Upstream keeps en asserted for the same store until stall=0; the store pushes exactly once.
- Reset mid-operation: FIFO flushed and pending bytes lost; LED/SEG cleared; tx_valid low the cycle after reset is sampled.

Test Plan:
- Reset, then sb addr=0x0103 data=0xAB -> dm_wen=1, dm_addr=0x0100, mask=8'h08, dm_wdata=0x00000000AB000000.
- sh to LED_ADDR data=0x1234, then sb to LED_ADDR+1 data=0xFF -> leds=0x1234, then leds=0xFF34.
- sw to 0x0102 -> misaligned=1, dm_wen=0, no state change. sd to TIMER_ADDR data=0xDEAD -> timer_wen=1, mask=8'hFF.
- tx_ready=0, 9 sb stores to UART_ADDR with bytes 0x41..0x49 (TX_DEPTH=8):
  - first 8 accepted, level=8.
  - 9th -> stall=1.
  - Raise tx_ready for one cycle -> 0x41 pops; next cycle stall=0 and 0x49 is pushed.
- tx_ready=1 continuously with back-to-back UART stores:
  - simultaneous push/pop keeps level constant.
  - output order 0x41,0x42,... preserved across pointer wrap (>16 bytes).
- Fill FIFO to 5, assert rst for one cycle -> level=0, tx_valid=0, leds=0, seg=0 at the next edge.
